// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit:
// FSM states, ALU operation codes, and the supported opcode/funct values.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  // Instructions whose second ALU operand is the sign-extended immediate.
  function automatic logic uses_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control-unit bundle: instruction fields, memory handshakes and datapath controls.
// The master side is the control unit; the slave side is the datapath/memories.
interface mips_mc_control_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       imem_req;
  logic       imem_ack;
  logic       dmem_ack;
  logic       IRWr;
  logic       PCWr;
  logic       RegDst;
  logic       RegWr;
  logic       ALUsrc;
  logic [1:0] ALUcntrl;
  logic       MemWr;
  logic       MemToReg;
  logic       Branch;
  logic       Jump;
  logic       illegal_op;
  logic       bus_err;

  modport master (
    input  opcode, funct, imem_ack, dmem_ack,
    output imem_req, IRWr, PCWr, RegDst, RegWr, ALUsrc, ALUcntrl,
           MemWr, MemToReg, Branch, Jump, illegal_op, bus_err
  );

  modport slave (
    output opcode, funct, imem_ack, dmem_ack,
    input  imem_req, IRWr, PCWr, RegDst, RegWr, ALUsrc, ALUcntrl,
           MemWr, MemToReg, Branch, Jump, illegal_op, bus_err
  );

endinterface

// File: rtl/mips_alu_decode.sv
// Combinational (opcode, funct) -> ALU operation decoder with a legality flag.
// j is legal but has no ALU use; anything undecodable reports legal = 0 and ADD.
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [1:0] alu_cntrl,
  output logic       legal
);

  // Opcode/funct to ALU operation map
  always_comb begin
    alu_cntrl = ALU_ADD;
    legal     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_ADD:  alu_cntrl = ALU_ADD;
          FN_SUB:  alu_cntrl = ALU_SUB;
          FN_AND:  alu_cntrl = ALU_AND;
          FN_OR:   alu_cntrl = ALU_OR;
          default: begin
            alu_cntrl = ALU_ADD;
            legal     = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_J: begin
        alu_cntrl = ALU_ADD;
        legal     = 1'b1;
      end
      OP_BEQ: begin
        alu_cntrl = ALU_SUB;
        legal     = 1'b1;
      end
      default: begin
        alu_cntrl = ALU_ADD;
        legal     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with imem timeout.
// Optional MIPS_MC_PERF_EN adds instret/cycles performance counters.
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int IMEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  mips_mc_control_if.master   ctl
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [31:0]         instret,
  output logic [31:0]         cycles
`endif
);

  localparam bit          TO_EN   = (IMEM_TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = 32'(IMEM_TIMEOUT) - 32'd1;

  state_t      state_r;
  state_t      next_state_s;
  logic        rst_hold_r;
  logic [5:0]  op_r;
  logic [5:0]  fn_r;
  logic [31:0] to_cnt_r;
  logic        bus_err_r;
  logic [1:0]  alu_s;
  logic        legal_s;
  logic        fetch_live_s;
  logic        ir_wr_s;

  // rst_hold_r keeps every output quiet for the first cycle after a reset edge
  assign fetch_live_s = (state_r == FETCH) && !rst_hold_r;
  assign ir_wr_s      = fetch_live_s && ctl.imem_ack;

  mips_alu_decode u_alu_decode (
    .opcode    (op_r),
    .funct     (fn_r),
    .alu_cntrl (alu_s),
    .legal     (legal_s)
  );

  // State register and instruction-field latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FETCH;
      rst_hold_r <= 1'b1;
      op_r       <= 6'd0;
      fn_r       <= 6'd0;
    end else begin
      state_r    <= next_state_s;
      rst_hold_r <= 1'b0;
      if (ir_wr_s) begin
        op_r <= ctl.opcode;
        fn_r <= ctl.funct;
      end else begin
        op_r <= op_r;
        fn_r <= fn_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH: begin
        if (ir_wr_s) next_state_s = DECODE;
        else         next_state_s = FETCH;
      end
      DECODE: begin
        if ((op_r == OP_J) || !legal_s) next_state_s = FETCH;
        else                            next_state_s = EXEC;
      end
      EXEC: begin
        case (op_r)
          OP_RTYPE, OP_ADDI: next_state_s = WB;
          OP_LW, OP_SW:      next_state_s = MEM;
          default:           next_state_s = FETCH;
        endcase
      end
      MEM: begin
        if (!ctl.dmem_ack)       next_state_s = MEM;
        else if (op_r == OP_LW)  next_state_s = WB;
        else                     next_state_s = FETCH;
      end
      WB:      next_state_s = FETCH;
      default: next_state_s = FETCH;
    endcase
  end

  // Moore control outputs; only IRWr/PCWr follow imem_ack inside FETCH
  always_comb begin
    ctl.imem_req   = 1'b0;
    ctl.IRWr       = 1'b0;
    ctl.PCWr       = 1'b0;
    ctl.RegDst     = 1'b0;
    ctl.RegWr      = 1'b0;
    ctl.ALUsrc     = 1'b0;
    ctl.ALUcntrl   = ALU_ADD;
    ctl.MemWr      = 1'b0;
    ctl.MemToReg   = 1'b0;
    ctl.Branch     = 1'b0;
    ctl.Jump       = 1'b0;
    ctl.illegal_op = 1'b0;
    if (rst_hold_r) begin
      ctl.imem_req = 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          ctl.imem_req = 1'b1;
          ctl.IRWr     = ctl.imem_ack;
          ctl.PCWr     = ctl.imem_ack;
        end
        DECODE: begin
          ctl.Jump       = (op_r == OP_J);
          ctl.illegal_op = !legal_s;
        end
        EXEC: begin
          ctl.ALUsrc   = uses_imm(op_r);
          ctl.ALUcntrl = alu_s;
          ctl.Branch   = (op_r == OP_BEQ);
        end
        MEM: begin
          ctl.ALUsrc   = uses_imm(op_r);
          ctl.ALUcntrl = alu_s;
          ctl.MemWr    = (op_r == OP_SW);
        end
        WB: begin
          ctl.RegWr    = 1'b1;
          ctl.RegDst   = (op_r == OP_RTYPE);
          ctl.MemToReg = (op_r == OP_LW);
        end
        default: begin
          ctl.imem_req = 1'b0;
        end
      endcase
    end
  end

  // Fetch timeout: count unacknowledged fetch cycles, pulse bus_err and retry
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r  <= 32'd0;
      bus_err_r <= 1'b0;
    end else if (fetch_live_s && !ctl.imem_ack) begin
      if (TO_EN && (to_cnt_r == TO_LAST)) begin
        to_cnt_r  <= 32'd0;
        bus_err_r <= 1'b1;
      end else begin
        to_cnt_r  <= to_cnt_r + 32'd1;
        bus_err_r <= 1'b0;
      end
    end else begin
      to_cnt_r  <= 32'd0;
      bus_err_r <= 1'b0;
    end
  end

  assign ctl.bus_err = bus_err_r;

`ifdef MIPS_MC_PERF_EN
  logic retire_s;

  // An instruction retires on its final transition back to FETCH, illegal ops excluded
  assign retire_s = (state_r != FETCH) && (next_state_s == FETCH) &&
                    !((state_r == DECODE) && !legal_s);

  // Performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= 32'd0;
      cycles  <= 32'd0;
    end else begin
      cycles <= cycles + 32'd1;
      if (retire_s) instret <= instret + 32'd1;
      else          instret <= instret;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: per-cycle stimulus and expected control
// vectors are queued from an instruction-level timing model, then replayed and compared.
module tb_mips_mc_control;

  localparam int TO = 5;

  typedef enum int {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

  typedef struct packed {
    logic       rst;
    logic       ia;
    logic       da;
    logic [5:0] op;
    logic [5:0] fn;
  } stim_t;

  typedef struct packed {
    logic       req;
    logic       irwr;
    logic       pcwr;
    logic       regdst;
    logic       regwr;
    logic       alusrc;
    logic [1:0] alu;
    logic       memwr;
    logic       m2r;
    logic       br;
    logic       jmp;
    logic       ill;
    logic       berr;
  } outv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mips_mc_control_if bus();

`ifdef MIPS_MC_PERF_EN
  logic [31:0] instret;
  logic [31:0] cycles;
`endif

  mips_mc_control #(.IMEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
`ifdef MIPS_MC_PERF_EN
    ,
    .instret (instret),
    .cycles  (cycles)
`endif
  );

  always #5 clk = ~clk;

  stim_t stim_q[$];
  outv_t exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    exp_ret = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic outv_t sample_dut();
    outv_t o;
    o.req    = bus.imem_req;
    o.irwr   = bus.IRWr;
    o.pcwr   = bus.PCWr;
    o.regdst = bus.RegDst;
    o.regwr  = bus.RegWr;
    o.alusrc = bus.ALUsrc;
    o.alu    = bus.ALUcntrl;
    o.memwr  = bus.MemWr;
    o.m2r    = bus.MemToReg;
    o.br     = bus.Branch;
    o.jmp    = bus.Jump;
    o.ill    = bus.illegal_op;
    o.berr   = bus.bus_err;
    return o;
  endfunction

  function automatic stim_t idle(input bit stray);
    stim_t s;
    s.rst = 1'b0;
    s.ia  = stray;
    s.da  = stray;
    s.op  = 6'b111111;
    s.fn  = 6'b111111;
    return s;
  endfunction

  task automatic push(input stim_t s, input outv_t e, input string tag);
    stim_q.push_back(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Queue one instruction: wi imem wait cycles, wd dmem wait cycles; abort = rst in lw MEM wait
  task automatic add_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input kind_t kind, input logic [1:0] alu, input int wi,
                           input int wd, input bit stray, input bit abort);
    stim_t s;
    outv_t e;
    for (int m = 0; m <= wi; m++) begin
      s = idle(stray);
      s.ia = (m == wi);
      if (m == wi) begin
        s.op = op;
        s.fn = fn;
      end
      e = '0;
      e.req  = 1'b1;
      e.irwr = (m == wi);
      e.pcwr = (m == wi);
      e.berr = (m > 0) && ((m % TO) == 0);
      push(s, e, $sformatf("%s.fetch%0d", name, m));
    end
    e = '0;
    e.jmp = (kind == K_J);
    e.ill = (kind == K_ILL);
    push(idle(stray), e, $sformatf("%s.decode", name));
    if (kind == K_ILL) return;
    if (kind == K_J) begin
      exp_ret++;
      return;
    end
    e = '0;
    e.alusrc = (kind == K_ADDI) || (kind == K_LW) || (kind == K_SW);
    e.alu    = alu;
    e.br     = (kind == K_BEQ);
    push(idle(stray), e, $sformatf("%s.exec", name));
    if (kind == K_BEQ) begin
      exp_ret++;
      return;
    end
    if ((kind == K_LW) || (kind == K_SW)) begin
      e = '0;
      e.alusrc = 1'b1;
      e.alu    = 2'b00;
      e.memwr  = (kind == K_SW);
      if (abort) begin
        for (int k = 0; k < wd; k++) begin
          s = idle(1'b0);
          s.rst = (k == wd - 1);
          push(s, e, $sformatf("%s.memwait%0d", name, k));
        end
        s = idle(1'b0);
        s.da = 1'b1;
        s.ia = 1'b1;
        push(s, outv_t'('0), $sformatf("%s.after_rst", name));
        return;
      end
      for (int k = 0; k <= wd; k++) begin
        s = idle(stray);
        s.da = (k == wd);
        push(s, e, $sformatf("%s.mem%0d", name, k));
      end
      if (kind == K_SW) begin
        exp_ret++;
        return;
      end
    end
    e = '0;
    e.regwr  = 1'b1;
    e.regdst = (kind == K_R);
    e.m2r    = (kind == K_LW);
    push(idle(stray), e, $sformatf("%s.wb", name));
    exp_ret++;
  endtask

  initial begin
    stim_t s;
    outv_t e;
    outv_t got;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.opcode   = 6'd0;
    bus.funct    = 6'd0;
    rst          = 1'b1;

    // Reset held over two edges with imem_ack high throughout
    s = idle(1'b0);
    s.rst = 1'b1;
    s.ia  = 1'b1;
    e = '0;
    push(s, e, "reset0");
    s.rst = 1'b0;
    push(s, e, "reset1");

    add_instr("addi",   6'b001000, 6'b000000, K_ADDI, 2'b00, 0, 0, 1'b0, 1'b0);
    add_instr("sub",    6'b000000, 6'b100010, K_R,    2'b01, 0, 0, 1'b0, 1'b0);
    add_instr("sw",     6'b101011, 6'b000000, K_SW,   2'b00, 0, 3, 1'b0, 1'b0);
    add_instr("lw",     6'b100011, 6'b000000, K_LW,   2'b00, 0, 0, 1'b0, 1'b0);
    add_instr("beq",    6'b000100, 6'b000000, K_BEQ,  2'b01, 0, 0, 1'b0, 1'b0);
    add_instr("j",      6'b000010, 6'b000000, K_J,    2'b00, 0, 0, 1'b0, 1'b0);
    add_instr("ill",    6'b111111, 6'b000000, K_ILL,  2'b00, 0, 0, 1'b0, 1'b0);
    add_instr("and",    6'b000000, 6'b100100, K_R,    2'b10, 2, 0, 1'b1, 1'b0);
    add_instr("or",     6'b000000, 6'b100101, K_R,    2'b11, 1, 0, 1'b1, 1'b0);
    add_instr("add",    6'b000000, 6'b100000, K_R,    2'b00, 0, 0, 1'b1, 1'b0);
    add_instr("badfn",  6'b000000, 6'b000001, K_ILL,  2'b00, 0, 0, 1'b1, 1'b0);
    add_instr("lw_w",   6'b100011, 6'b000000, K_LW,   2'b00, 1, 2, 1'b1, 1'b0);
    add_instr("sw_0",   6'b101011, 6'b000000, K_SW,   2'b00, 0, 0, 1'b1, 1'b0);
    add_instr("to7",    6'b001000, 6'b000000, K_ADDI, 2'b00, 7, 0, 1'b0, 1'b0);
    add_instr("to5",    6'b000100, 6'b000000, K_BEQ,  2'b01, 5, 0, 1'b0, 1'b0);
    add_instr("lw_abt", 6'b100011, 6'b000000, K_LW,   2'b00, 0, 2, 1'b0, 1'b1);
    add_instr("tail",   6'b001000, 6'b000000, K_ADDI, 2'b00, 0, 0, 1'b0, 1'b0);

    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk);
      #1;
      rst          = s.rst;
      bus.imem_ack = s.ia;
      bus.dmem_ack = s.da;
      bus.opcode   = s.op;
      bus.funct    = s.fn;
      @(negedge clk);
      got = sample_dut();
      check_val(tag_q.pop_front(), 32'(got), 32'(exp_q.pop_front()));
    end

`ifdef MIPS_MC_PERF_EN
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    check_val("instret", instret, 32'(exp_ret));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
Multi-cycle control unit for the MIPS datapath. It decodes the opcode and funct fields and sequences FETCH/DECODE/EXEC/MEM/WB. It drives the datapath control signals RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg, Branch and Jump, and handshakes with the instruction and data memories. The instruction fetch unit consumes Branch, Jump and PCWr, and combines them with the datapath Zero flag.

Parameters:
IMEM_TIMEOUT, 0, if nonzero: maximum cycles to wait for imem_ack before raising bus_err (0 = wait forever)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  Instructions[31:26]; sampled only when IRWr is asserted
funct  in  6  Instructions[5:0]; sampled with opcode
imem_req  out  1  instruction fetch request
imem_ack  in  1  instruction word valid on the current cycle
dmem_ack  in  1  data memory access complete
IRWr  out  1  instruction register load enable
PCWr  out  1  PC <- PC+4 enable
RegDst  out  1  1 = rd, 0 = rt
RegWr  out  1  register file write enable
ALUsrc  out  1  1 = sign-extended immediate
ALUcntrl  out  2  ALU operation
MemWr  out  1  data memory write
MemToReg  out  1  1 = write back load data
Branch  out  1  beq qualifier (IFU takes branch if Branch & Zero)
Jump  out  1  jump qualifier
illegal_op  out  1  one-cycle pulse on an undecodable instruction
bus_err  out  1  one-cycle pulse on imem timeout

Behaviour:
- Reset: state = FETCH. On the cycle after the rst edge all outputs are 0 (imem_req included), and latched opcode/funct are 0.
- rst asserted mid-instruction aborts it on the next edge. No RegWr/MemWr issues after that edge, and a pending imem_req/dmem wait is dropped.
- Outputs are Moore (decoded from the state register and latched op/funct). Don't-care fields drive 0, never X.
- FETCH: imem_req = 1. On imem_ack: IRWr = 1, PCWr = 1, latch opcode/funct, go to DECODE. Otherwise stay.
- DECODE:
  - j (000010): Jump = 1, go to FETCH.
  - Unknown opcode, or R-type with unknown funct: illegal_op = 1, go to FETCH with no writes.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: ALUsrc = 0, ALUcntrl per funct, go to WB.
  - addi (001000), lw (100011), sw (101011): ALUsrc = 1, ALUcntrl = ADD.
  - beq (000100): ALUsrc = 0, ALUcntrl = SUB, Branch = 1, go to FETCH.
  - addi goes to WB; lw and sw go to MEM.
- MEM: ALU controls held from EXEC.
  - sw: MemWr = 1 every cycle until dmem_ack, then go to FETCH.
  - lw: wait for dmem_ack, then go to WB.
  - dmem_ack arriving on the first MEM cycle gives a single-cycle MEM.
- WB: RegWr = 1 for exactly one cycle.
  - R-type: RegDst = 1, MemToReg = 0.
  - addi: RegDst = 0, MemToReg = 0.
  - lw: RegDst = 0, MemToReg = 1.
  - Then go to FETCH.
- ALUcntrl encoding: 00 ADD, 01 SUB, 10 AND, 11 OR. funct mapping: 100000 -> ADD, 100010 -> SUB, 100100 -> AND, 100101 -> OR.
- Latency with zero-wait acks (imem_ack on the first FETCH cycle):
  - j: 2 cycles
  - beq: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
- Each wait cycle on imem_ack or dmem_ack adds 1 cycle.
- imem_ack/dmem_ack outside FETCH/MEM are ignored.
- IMEM_TIMEOUT > 0: a counter increments each FETCH cycle without ack and clears on leaving FETCH. When it reaches IMEM_TIMEOUT: bus_err pulses, the counter clears, imem_req stays high and the fetch retries.
- Register writes never occur in the same cycle as MemWr.

Optional Feature:
MIPS_MC_PERF_EN
- Defined: adds output instret[31:0] and output cycles[31:0].
  - instret increments on every completed instruction: the last-state transition to FETCH, excluding illegal ops.
  - cycles increments every non-reset cycle.
  - Both clear on rst and wrap 0xFFFFFFFF -> 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum: FETCH, DECODE, EXEC, MEM, WB
  - ALUcntrl constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR
  - opcode and funct localparams
- Sub-module mips_alu_decode: combinational (opcode, funct) -> ALUcntrl plus a legal flag. Used by EXEC and by the DECODE illegal check.

Test Plan:
- rst held 2 cycles, then released with imem_ack = 1 continuously -> imem_req = 1 on the first cycle after release. All other outputs are 0 throughout reset.
- addi (opcode 001000), zero-wait -> IRWr/PCWr in cycle 1; EXEC has ALUsrc = 1, ALUcntrl = 00; WB in cycle 4 has RegWr = 1, RegDst = 0, MemToReg = 0; imem_req again in cycle 5.
- R-type sub (funct 100010) -> EXEC ALUcntrl = 01, ALUsrc = 0; WB RegDst = 1, RegWr = 1.
- sw with dmem_ack delayed 3 cycles -> MemWr high for exactly 4 cycles, RegWr never asserted, total 7 cycles.
- lw with zero wait -> MEM then WB with MemToReg = 1, RegDst = 0, RegWr = 1, 5 cycles total.
- beq -> Branch = 1 in EXEC (cycle 3). j -> Jump = 1 in DECODE (cycle 2). Opcode 111111 -> illegal_op pulse in cycle 2, no RegWr/MemWr. rst pulsed during an lw MEM wait -> FETCH next cycle, no RegWr.
